// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file access scheduler: FSM state encoding
// and the default debug starvation threshold.
package rf_sched_pkg;

  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADR  = 3'd1,
    RS1  = 3'd2,
    RS2  = 3'd3,
    WAIT = 3'd4,
    DRD  = 3'd5,
    DCAP = 3'd6,
    DWR  = 3'd7
  } sched_state_e;

endpackage

// File: rtl/rf_1r1w.sv
// 32x32 register storage, one write and one read port; read data appears one cycle
// after the address. A same-cycle write/read of one address returns the old contents.
module rf_1r1w (
  input  logic        clk,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rf_access_sched.sv
// Arbitrates the register file between pipeline operand reads and debug accesses.
// Operands land 1 cycle after each address; id_rfr_run holds the pipeline, writeback stalls debug writes.
module rf_access_sched
  import rf_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        cpu_stat_idrfr,
  input  logic [4:0]  inst_rs1,
  input  logic [4:0]  inst_rs2,
  input  logic [4:0]  rd_adr_wb,
  input  logic        wbk_rd_reg_wb,
  input  logic [31:0] wbk_data_wb,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_adr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        id_rfr_run,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  sched_state_e state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          starve;
  logic          dbg_go;
  logic          dbg_busy;
  logic          dwr_commit;
  logic [4:0]    raddr;
  logic [4:0]    raddr_q;
  logic [31:0]   ram_rdata;
  logic          ram_we;
  logic [4:0]    ram_waddr;
  logic [31:0]   ram_wdata;
  logic          fwd_hit;
  logic          fwd_vld;
  logic [4:0]    fwd_adr;
  logic [31:0]   fwd_dat;
  logic [31:0]   cap_dat;

  // dbg_req is still high during the ack cycle; masking it stops a duplicate grant.
  assign dbg_go   = dbg_req & ~dbg_ack;
  assign starve   = (starve_cnt == CW'(STARVE_LIMIT));
  assign dbg_busy = (state == DRD) | (state == DCAP) | (state == DWR);

  always_comb begin
    state_nxt  = state;
    raddr      = inst_rs1;
    dwr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (dbg_go && starve)                state_nxt = dbg_we ? DWR : DRD;
        else if (cpu_stat_idrfr && !stall)   state_nxt = ADR;
        else if (dbg_go)                     state_nxt = dbg_we ? DWR : DRD;
      end
      ADR: begin
        raddr     = inst_rs1;
        state_nxt = stall ? WAIT : RS1;
      end
      RS1: begin
        raddr     = inst_rs2;
        state_nxt = stall ? WAIT : RS2;
      end
      RS2:  state_nxt = WAIT;
      WAIT: state_nxt = IDLE;
      DRD: begin
        raddr     = dbg_adr;
        state_nxt = DCAP;
      end
      DCAP: state_nxt = IDLE;
      DWR: begin
        if (!wbk_rd_reg_wb) begin
          dwr_commit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writeback always wins the write port; x0 debug writes are acked but never stored.
  assign ram_we    = wbk_rd_reg_wb | (dwr_commit & (dbg_adr != 5'd0));
  assign ram_waddr = wbk_rd_reg_wb ? rd_adr_wb : dbg_adr;
  assign ram_wdata = wbk_rd_reg_wb ? wbk_data_wb : dbg_wdata;

  assign fwd_hit = wbk_rd_reg_wb & (rd_adr_wb != 5'd0) & (rd_adr_wb == raddr);
  assign cap_dat = (raddr_q == 5'd0)                   ? 32'd0   :
                   (fwd_vld && (fwd_adr == raddr_q))   ? fwd_dat : ram_rdata;

  assign id_rfr_run = (state == ADR) | (state == RS1) | (state == RS2) |
                      (cpu_stat_idrfr & ((state == IDLE) | dbg_busy));

  rf_1r1w u_rf (
    .clk   (clk),
    .raddr (raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= 32'd0;
      rs1_data   <= 32'd0;
      rs2_data   <= 32'd0;
      fwd_vld    <= 1'b0;
      fwd_adr    <= 5'd0;
      fwd_dat    <= 32'd0;
      raddr_q    <= 5'd0;
    end else begin
      state   <= state_nxt;
      dbg_ack <= (state == DCAP) | dwr_commit;
      fwd_vld <= fwd_hit;
      fwd_adr <= rd_adr_wb;
      fwd_dat <= wbk_data_wb;
      raddr_q <= raddr;
      if (dbg_ack)                              starve_cnt <= '0;
      else if (dbg_req && !dbg_busy && !starve) starve_cnt <= starve_cnt + CW'(1);
      if (state == RS1)  rs1_data  <= cap_dat;
      if (state == RS2)  rs2_data  <= cap_dat;
      if (state == DCAP) dbg_rdata <= cap_dat;
    end
  end

endmodule

// File: tb/tb_rf_access_sched.sv
// Randomized scoreboard bench for rf_access_sched against a register-array reference model.
module tb_rf_access_sched;

  localparam int SL = rf_sched_pkg::STARVE_LIMIT_DEF;

  logic        clk, rst_n, stall, cpu_stat_idrfr;
  logic [4:0]  inst_rs1, inst_rs2, rd_adr_wb, dbg_adr;
  logic        wbk_rd_reg_wb, dbg_req, dbg_we;
  logic [31:0] wbk_data_wb, dbg_wdata;
  logic        dbg_ack, id_rfr_run;
  logic [31:0] dbg_rdata, rs1_data, rs2_data;

  rf_access_sched #(.STARVE_LIMIT(SL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .cpu_stat_idrfr (cpu_stat_idrfr),
    .inst_rs1       (inst_rs1),
    .inst_rs2       (inst_rs2),
    .rd_adr_wb      (rd_adr_wb),
    .wbk_rd_reg_wb  (wbk_rd_reg_wb),
    .wbk_data_wb    (wbk_data_wb),
    .dbg_req        (dbg_req),
    .dbg_we         (dbg_we),
    .dbg_adr        (dbg_adr),
    .dbg_wdata      (dbg_wdata),
    .dbg_ack        (dbg_ack),
    .dbg_rdata      (dbg_rdata),
    .id_rfr_run     (id_rfr_run),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] rs1; logic [31:0] rs2; int run_len; } cpu_exp_t;
  typedef struct { bit is_read; logic [31:0] rdata; } dbg_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_rf [32];
  logic [31:0] exp_rs1 = 32'd0;
  logic [31:0] exp_rs2 = 32'd0;
  bit          cpu_mon_en = 1'b1;
  cpu_exp_t    cpu_q[$];
  dbg_exp_t    dbg_q[$];

  function automatic logic [31:0] rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : ref_rf[a];
  endfunction

  function automatic logic [4:0] rand_adr();
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A writeback driven in a cycle is committed at that cycle's closing edge.
  task automatic wbk_set(input bit en, input logic [4:0] a, input logic [31:0] d);
    wbk_rd_reg_wb = en;
    rd_adr_wb     = a;
    wbk_data_wb   = d;
    if (en) ref_rf[a] = d;
  endtask

  task automatic idle(input int n);
    cpu_stat_idrfr = 1'b0;
    dbg_req        = 1'b0;
    stall          = 1'b0;
    wbk_set(1'b0, 5'd0, 32'd0);
    repeat (n) step();
  endtask

  // stall_at: 0 none, 1 stall during the rs1 address cycle, 2 during the rs2 address cycle.
  task automatic cpu_op(input logic [4:0] r1, input logic [4:0] r2, input int stall_at,
                        input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                        input bit w2, input logic [4:0] a2, input logic [31:0] d2);
    cpu_exp_t e;
    inst_rs1 = r1;
    inst_rs2 = r2;
    cpu_stat_idrfr = 1'b1;
    step();
    cpu_stat_idrfr = 1'b0;
    wbk_set(w1, a1, d1);
    stall = (stall_at == 1);
    if (stall_at != 1) exp_rs1 = rd(r1);
    step();
    wbk_set(1'b0, 5'd0, 32'd0);
    stall = 1'b0;
    if (stall_at == 1) begin
      e.run_len = 2;
    end else begin
      wbk_set(w2, a2, d2);
      stall = (stall_at == 2);
      if (stall_at != 2) exp_rs2 = rd(r2);
      e.run_len = (stall_at == 2) ? 3 : 4;
      step();
      wbk_set(1'b0, 5'd0, 32'd0);
      stall = 1'b0;
    end
    e.rs1 = exp_rs1;
    e.rs2 = exp_rs2;
    cpu_q.push_back(e);
    idle(3);
  endtask

  task automatic dbg_op(input bit we, input logic [4:0] adr, input logic [31:0] wd,
                        input int n_busy, input bit fwd, input logic [31:0] fd);
    dbg_exp_t e;
    int lat = 0;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_adr   = adr;
    dbg_wdata = wd;
    while (lat < 40) begin
      step();
      lat++;
      if (dbg_ack) break;
      if (we) begin
        if (lat <= n_busy) begin
          wbk_set(1'b1, 5'($urandom_range(1, 31)), $urandom);
        end else begin
          wbk_set(1'b0, 5'd0, 32'd0);
          if (lat == n_busy + 1) begin
            if (adr != 5'd0) ref_rf[adr] = wd;
            e.is_read = 1'b0;
            e.rdata   = 32'd0;
            dbg_q.push_back(e);
          end
        end
      end else if (lat == 1) begin
        wbk_set(fwd, adr, fd);
        e.is_read = 1'b1;
        e.rdata   = rd(adr);
        dbg_q.push_back(e);
      end else begin
        wbk_set(1'b0, 5'd0, 32'd0);
      end
    end
    wbk_set(1'b0, 5'd0, 32'd0);
    chk(we ? "dbg_write_ack_latency" : "dbg_read_ack_latency", lat, we ? (n_busy + 2) : 3);
    idle(2);
  endtask

  // Scoreboard monitor: debug results pop on dbg_ack, operand pairs pop when id_rfr_run drops.
  initial begin
    logic     prev_run, prev_ack;
    int       run;
    dbg_exp_t de;
    cpu_exp_t ce;
    prev_run = 1'b0;
    prev_ack = 1'b0;
    run      = 0;
    forever begin
      @(negedge clk);
      if (dbg_ack) begin
        chk("dbg_ack_single_pulse", {31'd0, prev_ack}, 32'd0);
        if (dbg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dbg_unexpected_ack: ack with no pending request (t=%0t)", $time);
        end else begin
          de = dbg_q.pop_front();
          if (de.is_read) chk("dbg_rdata", dbg_rdata, de.rdata);
        end
      end
      if (id_rfr_run) begin
        run++;
      end else begin
        if (prev_run && cpu_mon_en) begin
          if (cpu_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cpu_unexpected_seq: run ended with no pending read (t=%0t)", $time);
          end else begin
            ce = cpu_q.pop_front();
            chk("rs1_data", rs1_data, ce.rs1);
            chk("rs2_data", rs2_data, ce.rs2);
            chk("id_rfr_run_len", run, ce.run_len);
          end
        end
        run = 0;
      end
      prev_run = id_rfr_run;
      prev_ack = dbg_ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  hist;
    logic [31:0] old9;
    dbg_exp_t    e;
    int          lat;
    rst_n = 1'b0;
    inst_rs1 = 5'd0;
    inst_rs2 = 5'd0;
    dbg_we = 1'b0;
    dbg_adr = 5'd0;
    dbg_wdata = 32'd0;
    idle(0);
    #3;
    chk("reset_rs1_data", rs1_data, 32'd0);
    chk("reset_rs2_data", rs2_data, 32'd0);
    chk("reset_dbg_rdata", dbg_rdata, 32'd0);
    chk("reset_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("reset_id_rfr_run", {31'd0, id_rfr_run}, 32'd0);
    #20 rst_n = 1'b1;
    step();

    for (int i = 1; i < 32; i++) begin
      wbk_set(1'b1, 5'(i), $urandom);
      step();
    end
    wbk_set(1'b1, 5'd5, 32'h1234); step();
    wbk_set(1'b1, 5'd6, 32'hABCD); step();
    idle(2);

    cpu_op(5'd5, 5'd6, 0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    wbk_set(1'b1, 5'd5, 32'h1111); step();
    wbk_set(1'b1, 5'd6, 32'h2222); step();
    idle(1);
    cpu_op(5'd5, 5'd6, 2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cpu_op(5'd8, 5'd9, 1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cpu_op(5'd7, 5'd6, 0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0);
    cpu_op(5'd0, 5'd10, 0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0BAD_F00D);
    dbg_op(1'b1, 5'd3, 32'hDEAD, 2, 1'b0, 32'd0);
    dbg_op(1'b0, 5'd3, 32'd0, 0, 1'b0, 32'd0);
    dbg_op(1'b0, 5'd0, 32'd0, 0, 1'b0, 32'd0);
    dbg_op(1'b1, 5'd0, 32'hFFFF_FFFF, 0, 1'b0, 32'd0);
    dbg_op(1'b0, 5'd0, 32'd0, 0, 1'b0, 32'd0);
    dbg_op(1'b0, 5'd4, 32'd0, 0, 1'b1, 32'hCAFE);

    for (int i = 0; i < 150; i++) begin
      logic [4:0] r1, r2;
      int k;
      r1 = rand_adr();
      r2 = rand_adr();
      case ($urandom_range(0, 3))
        0: begin
          wbk_set(1'b1, rand_adr(), $urandom);
          step();
          idle(1);
        end
        1: begin
          k = $urandom_range(0, 5);
          cpu_op(r1, r2, (k == 0) ? 1 : (k == 1) ? 2 : 0,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? r1 : rand_adr(), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? r2 : rand_adr(), $urandom);
        end
        2: dbg_op(1'b0, r1, 32'd0, 0, 1'($urandom_range(0, 1)), $urandom);
        default: dbg_op(1'b1, r1, $urandom, $urandom_range(0, 3), 1'b0, 32'd0);
      endcase
    end

    // Pipeline requests continuously; the pending debug read must still get through.
    cpu_mon_en = 1'b0;
    inst_rs1 = 5'd5;
    inst_rs2 = 5'd6;
    cpu_stat_idrfr = 1'b1;
    repeat (3) step();
    dbg_req = 1'b1;
    dbg_we  = 1'b0;
    dbg_adr = 5'd3;
    e.is_read = 1'b1;
    e.rdata   = rd(5'd3);
    dbg_q.push_back(e);
    lat  = 0;
    hist = 3'b000;
    while (lat < 60) begin
      step();
      lat++;
      hist = {hist[1:0], id_rfr_run};
      if (dbg_ack) break;
    end
    chk("starve_grant_not_late", 32'(lat <= SL + 7), 32'd1);
    chk("starve_grant_not_early", 32'(lat >= SL + 3), 32'd1);
    chk("run_high_during_dbg", {29'd0, hist}, 32'd7);
    idle(6);
    chk("starve_rs1_data", rs1_data, rd(5'd5));
    chk("starve_rs2_data", rs2_data, rd(5'd6));
    exp_rs1 = rd(5'd5);
    exp_rs2 = rd(5'd6);
    cpu_mon_en = 1'b1;

    // Reset lands while a debug write is about to commit: no ack, no write.
    old9 = rd(5'd9);
    dbg_req = 1'b1;
    dbg_we = 1'b1;
    dbg_adr = 5'd9;
    dbg_wdata = ~old9;
    step();
    rst_n = 1'b0;
    #1;
    chk("midreset_rs1_data", rs1_data, 32'd0);
    chk("midreset_rs2_data", rs2_data, 32'd0);
    chk("midreset_dbg_rdata", dbg_rdata, 32'd0);
    chk("midreset_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("midreset_id_rfr_run", {31'd0, id_rfr_run}, 32'd0);
    dbg_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_rs1 = 32'd0;
    exp_rs2 = 32'd0;
    idle(2);
    dbg_op(1'b0, 5'd9, 32'd0, 0, 1'b0, 32'd0);
    cpu_op(5'd9, 5'd3, 1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(4);

    chk("cpu_queue_drained", cpu_q.size(), 32'd0);
    chk("dbg_queue_drained", dbg_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
